// File: rtl/bk_adder_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder.
// pg_t carries a (generate, propagate) pair; dot() is the prefix operator
// combining a less-significant span (lo) with a more-significant span (hi).
package bk_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Ceiling log2, used to size the sweep trees at elaboration time.
    function automatic int log2w(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

    // (gl,pl) o (gh,ph) = (gh | ph&gl, ph&pl)
    function automatic pg_t dot(input pg_t lo, input pg_t hi);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/bk_dot_cell.sv
// Combinational Brent-Kung dot cell: merges a low span into a high span.
module bk_dot_cell
    import bk_adder_pkg::*;
(
    input  pg_t lo_i,
    input  pg_t hi_i,
    output pg_t out_o
);

    assign out_o = dot(lo_i, hi_i);

endmodule

// File: rtl/brent_kung_pipe_adder.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow.
//   S1: operand prep (P, G, folded carry-in), S2: up-sweep, S3: down-sweep + sum.
// Optional feature: define BK_OVERFLOW_EN to add the registered signed
// overflow output out_ovf; without it the port and its logic are absent.
// Handshake: a beat moves on a side when valid & ready are both high in the
// same cycle; in_ready = advance = !out_valid | out_ready, so the whole
// pipeline shifts as one and holds as one (bubbles are kept, not squeezed).
module brent_kung_pipe_adder
    import bk_adder_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef BK_OVERFLOW_EN
   ,output logic             out_ovf
`endif
);

    localparam int LOG2W = log2w(WIDTH);

    if (WIDTH < 4 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("brent_kung_pipe_adder: WIDTH must be a power of two in 4..128");
    end

    logic advance;
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- S1: operand prep ----------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p1_d, g1_d;
    logic             cin1_d;
    logic [WIDTH-1:0] p1_q, g1_q;
    logic             cin1_q, v1_q;

    assign b_eff  = in_sub ? ~in_b : in_b;
    assign cin1_d = in_cin ^ in_sub;
    assign p1_d   = in_a ^ b_eff;
    // Carry-in is folded into bit 0 so the prefix tree needs no extra input.
    assign g1_d   = {in_a[WIDTH-1:1] & b_eff[WIDTH-1:1],
                     (in_a[0] & b_eff[0]) | (p1_d[0] & cin1_d)};

    // Stage 1 register: bit P/G, effective carry-in and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            p1_q   <= '0;
            g1_q   <= '0;
            cin1_q <= 1'b0;
        end else if (advance) begin
            v1_q   <= in_valid;
            p1_q   <= p1_d;
            g1_q   <= g1_d;
            cin1_q <= cin1_d;
        end
    end

    // ---------------- S2: up-sweep ----------------
    pg_t up [0:LOG2W][0:WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_up_in
        assign up[0][i] = '{g: g1_q[i], p: p1_q[i]};
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_up_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_up_bit
            if (((i + 1) % (1 << (k + 1))) == 0) begin : g_dot
                bk_dot_cell u_dot (
                    .lo_i  (up[k][i - (1 << k)]),
                    .hi_i  (up[k][i]),
                    .out_o (up[k+1][i])
                );
            end else begin : g_pass
                assign up[k+1][i] = up[k][i];
            end
        end
    end

    pg_t              node2_q [0:WIDTH-1];
    logic [WIDTH-1:0] p2_q;
    logic             cin2_q, v2_q;

    // Stage 2 register: group (G,P) after the up-sweep plus raw bit P.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            p2_q   <= '0;
            cin2_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) node2_q[i] <= '0;
        end else if (advance) begin
            v2_q   <= v1_q;
            p2_q   <= p1_q;
            cin2_q <= cin1_q;
            for (int i = 0; i < WIDTH; i++) node2_q[i] <= up[LOG2W][i];
        end
    end

    // ---------------- S3: down-sweep + sum ----------------
    pg_t dn [0:LOG2W-1][0:WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_dn_in
        assign dn[0][i] = node2_q[i];
    end

    // Level j fills the positions halfway between already-complete prefixes.
    for (genvar j = 0; j < LOG2W - 1; j++) begin : g_dn_lvl
        localparam int SPAN = 1 << (LOG2W - 2 - j);
        for (genvar i = 0; i < WIDTH; i++) begin : g_dn_bit
            if (i >= 2 * SPAN && ((i + 1) % (2 * SPAN)) == SPAN) begin : g_dot
                bk_dot_cell u_dot (
                    .lo_i  (dn[j][i - SPAN]),
                    .hi_i  (dn[j][i]),
                    .out_o (dn[j+1][i])
                );
            end else begin : g_pass
                assign dn[j+1][i] = dn[j][i];
            end
        end
    end

    logic [WIDTH-1:0] carry;
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign carry[i] = dn[LOG2W-1][i].g;
    end

    logic [WIDTH-1:0] sum3_d, sum3_q;
    logic             cout3_q, v3_q;

    assign sum3_d = p2_q ^ {carry[WIDTH-2:0], cin2_q};

`ifdef BK_OVERFLOW_EN
    logic ovf3_q;
    // Overflow register, aligned with the sum.
    always_ff @(posedge clk) begin
        if (!rst_n)       ovf3_q <= 1'b0;
        else if (advance) ovf3_q <= carry[WIDTH-1] ^ carry[WIDTH-2];
    end
    assign out_ovf = ovf3_q;
`endif

    // Stage 3 register: presented result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3_q    <= 1'b0;
            sum3_q  <= '0;
            cout3_q <= 1'b0;
        end else if (advance) begin
            v3_q    <= v2_q;
            sum3_q  <= sum3_d;
            cout3_q <= carry[WIDTH-1];
        end
    end

    assign out_valid = v3_q;
    assign out_sum   = sum3_q;
    assign out_cout  = cout3_q;

endmodule
